// File: rtl/ro_freq_counter.sv
// Ring-oscillator channel mux with a gated rising-edge frequency counter.
// One measurement engine serves NUM_CH oscillator outputs selected by ch_sel.
module ro_freq_counter #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned GATE_W = 16,
  parameter int unsigned CNT_W  = 24
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              ch_out
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StCount  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GATE_W-1:0] g_q, g_d;
  logic [GATE_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              ch_mux;
  logic              rise;

  // Out-of-range selects fall through to the constant 0 default.
  always_comb begin
    ch_mux = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sel_q == SEL_W'(i)) begin
        ch_mux = ro_in[i];
      end
    end
  end

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    g_d        = g_q;
    tmr_d      = tmr_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          sel_d   = ch_sel;
          g_d     = gate_cycles;
          tmr_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end

      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_q == GATE_W'(2)) begin
          tmr_d = '0;
          if (g_q == '0) begin
            state_d    = StDone;
            count_d    = acc_q;
            overflow_d = sat_q;
          end else begin
            state_d = StCount;
          end
        end else begin
          tmr_d = tmr_q + GATE_W'(1);
        end
      end

      StCount: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (rise) begin
            if (&acc_q) begin
              sat_d = 1'b1;
            end else begin
              acc_d = acc_q + CNT_W'(1);
            end
          end
          // Result is captured on the edge into DONE so it is valid with done.
          if (tmr_q == g_q - GATE_W'(1)) begin
            state_d    = StDone;
            count_d    = acc_d;
            overflow_d = sat_d;
          end else begin
            tmr_d = tmr_q + GATE_W'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      g_q        <= '0;
      tmr_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      g_q        <= g_d;
      tmr_q      <= tmr_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sync1_q    <= ch_mux;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
    end
  end

  assign busy     = (state_q == StSettle) || (state_q == StCount);
  assign done     = (state_q == StDone);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign ch_out   = ch_mux;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: two instances (default and narrow-counter/12-channel)
// share one oscillator bus; expected counts come from the recorded input history.
module tb_ro_freq_counter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] ro;
  logic [3:0]  sel_a, sel_b;
  logic [15:0] gate_a;
  logic [7:0]  gate_b;
  logic        start_a, start_b, abort_a, abort_b;
  logic        busy_a, done_a, ovf_a, cho_a;
  logic        busy_b, done_b, ovf_b, cho_b;
  logic [23:0] count_a;
  logic [3:0]  count_b;

  ro_freq_counter #(.NUM_CH(16), .SEL_W(4), .GATE_W(16), .CNT_W(24)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .ro_in(ro), .ch_sel(sel_a), .gate_cycles(gate_a),
    .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a), .count(count_a),
    .overflow(ovf_a), .ch_out(cho_a)
  );

  ro_freq_counter #(.NUM_CH(12), .SEL_W(4), .GATE_W(8), .CNT_W(4)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .ro_in(ro[11:0]), .ch_sel(sel_b), .gate_cycles(gate_b),
    .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b), .count(count_b),
    .overflow(ovf_b), .ch_out(cho_b)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] hist [0:16383];
  int          per [16];
  int          lsel_a = 0, lsel_b = 0;
  longint      last_cnt_a = 0, last_cnt_b = 0;
  longint      last_ovf_a = 0, last_ovf_b = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Channel value as seen by an instance with nch inputs; absent channels read 0.
  function automatic bit rbit(input int c, input int ch, input int nch);
    if (ch >= nch) return 1'b0;
    return hist[c][ch];
  endfunction

  // Rising edges of the chosen channel during the G-cycle window, seen two cycles late.
  function automatic longint edges(input int c0, input int ch, input int nch, input int g);
    longint e = 0;
    for (int x = c0 + 4; x <= c0 + 3 + g; x++) begin
      if (rbit(x - 2, ch, nch) && !rbit(x - 3, ch, nch)) e++;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= 16000) begin
      $display("FAIL tick_budget: observed %0d cycles, limit 16000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    for (int i = 0; i < 16; i++) begin
      if (per[i] == 0) ro[i] = 1'($urandom);
      else             ro[i] = ((cyc % per[i]) < (per[i] / 2));
    end
    hist[cyc] = ro;
    #1;
  endtask

  // abort_at > 0: abort high in that cycle; -1: abort asserted together with start.
  task automatic meas(input bit b, input int ch, input int g, input int abort_at,
                      input int poke_at, input int poke_ch);
    int     c0, nch;
    longint e, maxv, ec, eo;
    logic   bz, dn, co, ov;
    logic [63:0] cnt;
    nch  = b ? 12 : 16;
    maxv = b ? 15 : 64'hFF_FFFF;
    if (b) begin sel_b = 4'(ch); gate_b = 8'(g); start_b = 1'b1; abort_b = (abort_at == -1); end
    else   begin sel_a = 4'(ch); gate_a = 16'(g); start_a = 1'b1; abort_a = (abort_at == -1); end
    c0 = cyc;
    for (int n = 1; n <= g + 4; n++) begin
      tick();
      if (n == 1) begin
        if (b) begin start_b = 1'b0; abort_b = 1'b0; lsel_b = ch; end
        else   begin start_a = 1'b0; abort_a = 1'b0; lsel_a = ch; end
      end
      if (poke_at > 0 && n == poke_at) begin
        if (b) begin sel_b = 4'(poke_ch); start_b = 1'b1; end
        else   begin sel_a = 4'(poke_ch); start_a = 1'b1; end
      end
      if (poke_at > 0 && n == g + 2) begin
        if (b) start_b = 1'b0; else start_a = 1'b0;
      end
      bz  = b ? busy_b : busy_a;
      dn  = b ? done_b : done_a;
      co  = b ? cho_b : cho_a;
      ov  = b ? ovf_b : ovf_a;
      cnt = b ? 64'(count_b) : 64'(count_a);
      chk("ch_out_follow", co, rbit(cyc, ch, nch));
      if (abort_at > 0 && n == abort_at + 1) begin
        if (b) abort_b = 1'b0; else abort_a = 1'b0;
        chk("abort_busy", bz, 0);
        chk("abort_done", dn, 0);
        chk("abort_count_kept", cnt, b ? last_cnt_b : last_cnt_a);
        chk("abort_ovf_kept", ov, b ? last_ovf_b : last_ovf_a);
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("abort_no_done", b ? done_b : done_a, 0);
        end
        return;
      end
      if (n < g + 4) begin
        chk("busy_during", bz, 1);
        chk("done_early", dn, 0);
        chk("count_stable", cnt, b ? last_cnt_b : last_cnt_a);
      end else begin
        e  = edges(c0, ch, nch, g);
        ec = (e > maxv) ? maxv : e;
        eo = (e > maxv) ? 1 : 0;
        chk("done_at_g4", dn, 1);
        chk("busy_in_done", bz, 0);
        chk("count", cnt, ec);
        chk("overflow", ov, eo);
        if (b) begin last_cnt_b = ec; last_ovf_b = eo; end
        else   begin last_cnt_a = ec; last_ovf_a = eo; end
      end
      if (abort_at > 0 && n == abort_at) begin
        if (b) abort_b = 1'b1; else abort_a = 1'b1;
      end
    end
    tick();
    chk("done_one_cycle", b ? done_b : done_a, 0);
    chk("idle_after_done", b ? busy_b : busy_a, 0);
  endtask

  initial begin
    int   ch, g, ab;
    logic seen;
    for (int i = 0; i < 16; i++) per[i] = 0;
    per[5] = 4;
    per[9] = 8;
    per[2] = 2;
    ro = '0;
    hist[0] = '0;
    sel_a = '0; sel_b = '0; gate_a = '0; gate_b = '0;
    start_a = 0; start_b = 0; abort_a = 0; abort_b = 0;
    rst_a = 1; rst_b = 1;
    tick();
    tick();
    rst_a = 0; rst_b = 0;
    tick();

    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_chout_a", cho_a, ro[0]);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_count_b", count_b, 0);
    chk("rst_chout_b", cho_b, ro[0]);

    meas(0, 5, 100, 0, 0, 0);
    chk("sq4_count25", count_a, 25);
    meas(0, 3, 200, 50, 0, 0);
    chk("abort_keeps25", count_a, 25);
    meas(0, 3, 40, 0, 10, 9);
    meas(0, 9, 80, 0, 0, 0);
    chk("sq8_count10", count_a, 10);
    meas(0, 7, 0, 0, 0, 0);
    chk("g0_count0", count_a, 0);
    meas(0, 11, 12, -1, 0, 0);

    for (int r = 0; r < 10; r++) begin
      ch = $urandom_range(0, 15);
      g  = $urandom_range(0, 40);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, g + 3) : 0;
      meas(0, ch, g, ab, 0, 0);
      for (int k = $urandom_range(0, 3); k > 0; k--) tick();
    end

    meas(1, 2, 64, 0, 0, 0);
    chk("sat_count15", count_b, 15);
    chk("sat_ovf", ovf_b, 1);
    meas(1, 14, 20, 0, 0, 0);
    chk("oor_count0", count_b, 0);
    chk("oor_chout0", cho_b, 0);
    for (int r = 0; r < 4; r++) begin
      meas(1, $urandom_range(0, 11), $urandom_range(0, 30), 0, 0, 0);
    end

    // Asynchronous reset mid-COUNT on the narrow instance.
    meas(1, 2, 8, 0, 0, 0);
    sel_b = 4'd2; gate_b = 8'd50; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("pre_rst_busy", busy_b, 1);
    rst_b = 1'b1;
    #1;
    chk("midrst_busy", busy_b, 0);
    chk("midrst_count", count_b, 0);
    chk("midrst_ovf", ovf_b, 0);
    chk("midrst_done", done_b, 0);
    tick();
    rst_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      seen = seen | done_b | busy_b;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_chout_sel0", cho_b, ro[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
